// File: rtl/alu_multicycle.sv
// Registered ALU with single-cycle ops (latency 1) and iterative signed MUL/DIV (WIDTH+1 cycles) behind start/busy/data_ready.
// Define ALU_DIV_EN to build the restoring divider; otherwise opcode 7 completes at once with data_exception set.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [4:0]         ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               overflow,
  output logic               data_exception,
  output logic               data_ready,
  output logic               busy
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [4:0] OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4, OP_SRA = 5'd5, OP_MUL = 5'd6, OP_DIV = 5'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  state_t state, state_nxt;

  logic               accept, iter_op;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   sum, diff, sc_res;
  logic               sc_ovf;
  logic [2*WIDTH-1:0] prod, mcand, prod_nxt, prod_sgn;
  logic [WIDTH-1:0]   mplier;
  logic               mul_ovf;

  assign accept = ctrl_start && !busy;
  assign a_mag  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
`ifdef ALU_DIV_EN
  assign iter_op = (ctrl_ALUopcode == OP_MUL) ||
                   ((ctrl_ALUopcode == OP_DIV) && (data_operandB != '0));
`else
  assign iter_op = (ctrl_ALUopcode == OP_MUL);
`endif

  assign sum  = data_operandA + data_operandB;
  assign diff = data_operandA - data_operandB;

  always_comb begin
    sc_res = sum;
    sc_ovf = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
             (sum[WIDTH-1] != data_operandA[WIDTH-1]);
    case (ctrl_ALUopcode)
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (data_operandA[WIDTH-1] == ~data_operandB[WIDTH-1]) &&
                 (diff[WIDTH-1] != data_operandA[WIDTH-1]);
      end
      OP_AND: begin sc_res = data_operandA & data_operandB; sc_ovf = 1'b0; end
      OP_OR:  begin sc_res = data_operandA | data_operandB; sc_ovf = 1'b0; end
      OP_SLL: begin sc_res = data_operandA << ctrl_shiftamt; sc_ovf = 1'b0; end
      OP_SRA: begin sc_res = $signed(data_operandA) >>> ctrl_shiftamt; sc_ovf = 1'b0; end
      default: ;
    endcase
  end

  // Shift-add on magnitudes; the final step is folded into the completing edge.
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign prod_sgn = neg ? -prod_nxt : prod_nxt;
  assign mul_ovf  = prod_sgn[2*WIDTH-1:WIDTH] != {WIDTH{prod_sgn[WIDTH-1]}};

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] quo, rem, dvs, quo_nxt, quo_sgn;
  logic [WIDTH:0]   rem_sh, rem_dif;
  logic             div_ovf;

  // Restoring step: a borrow out of the trial subtraction means the quotient bit is 0.
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_dif = rem_sh - {1'b0, dvs};
  assign quo_nxt = {quo[WIDTH-2:0], ~rem_dif[WIDTH]};
  assign quo_sgn = neg ? -quo_nxt : quo_nxt;
  assign div_ovf = (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && iter_op)
          state_nxt = (ctrl_ALUopcode == OP_MUL) ? S_MUL : S_DIV;
      end
      S_MUL, S_DIV: begin
        if (cnt == LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= '0;
      isNotEqual     <= 1'b0;
      isLessThan     <= 1'b0;
      overflow       <= 1'b0;
      data_exception <= 1'b0;
      data_ready     <= 1'b0;
      cnt            <= '0;
      op_a           <= '0;
      op_b           <= '0;
      neg            <= 1'b0;
      prod           <= '0;
      mcand          <= '0;
      mplier         <= '0;
`ifdef ALU_DIV_EN
      quo            <= '0;
      rem            <= '0;
      dvs            <= '0;
`endif
    end else begin
      data_ready <= 1'b0;
      if (accept) begin
        op_a   <= data_operandA;
        op_b   <= data_operandB;
        neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        cnt    <= '0;
        prod   <= '0;
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
`ifdef ALU_DIV_EN
        quo    <= a_mag;
        rem    <= '0;
        dvs    <= b_mag;
`endif
        if (!iter_op) begin
          data_ready <= 1'b1;
          isNotEqual <= data_operandA != data_operandB;
          isLessThan <= $signed(data_operandA) < $signed(data_operandB);
          if (ctrl_ALUopcode == OP_DIV) begin
            data_result    <= '0;
            overflow       <= 1'b0;
            data_exception <= 1'b1;
          end else begin
            data_result    <= sc_res;
            overflow       <= sc_ovf;
            data_exception <= 1'b0;
          end
        end
      end else if (busy) begin
        cnt    <= cnt + 1'b1;
        prod   <= prod_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
`ifdef ALU_DIV_EN
        quo    <= quo_nxt;
        rem    <= rem_dif[WIDTH] ? rem_sh[WIDTH-1:0] : rem_dif[WIDTH-1:0];
`endif
        if (cnt == LAST) begin
          data_ready     <= 1'b1;
          isNotEqual     <= op_a != op_b;
          isLessThan     <= $signed(op_a) < $signed(op_b);
          data_exception <= 1'b0;
`ifdef ALU_DIV_EN
          if (state == S_DIV) begin
            data_result <= quo_sgn;
            overflow    <= div_ovf;
          end else begin
            data_result <= prod_sgn[WIDTH-1:0];
            overflow    <= mul_ovf;
          end
`else
          data_result <= prod_sgn[WIDTH-1:0];
          overflow    <= mul_ovf;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vectors, an arithmetic reference model with a completion queue,
// and a per-cycle compare of data_ready/busy/result fields against that model.
module tb_alu_multicycle;
  localparam int W = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_start = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [4:0]   ctrl_ALUopcode = '0;
  logic [4:0]   ctrl_shiftamt = '0;
  logic [W-1:0] data_result;
  logic         isNotEqual, isLessThan, overflow, data_exception, data_ready, busy;

  typedef struct {
    int           due;
    logic [W-1:0] res;
    logic         ne;
    logic         lt;
    logic         ovf;
    logic         exc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   busy_start = 0;
  int   busy_end = 0;
  int   checks = 0;
  int   errors = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .ctrl_start(ctrl_start),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
    .data_result(data_result), .isNotEqual(isNotEqual), .isLessThan(isLessThan),
    .overflow(overflow), .data_exception(data_exception),
    .data_ready(data_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic bit iterative(input logic [4:0] op, input logic [W-1:0] b);
    return (op == 5'd6) || (DIV_EN && op == 5'd7 && b != '0);
  endfunction

  // Reference results from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [4:0] sh);
    exp_t   e;
    longint r;
    e.due = 0;
    e.ne  = (a != b);
    e.lt  = (sx(a) < sx(b));
    e.ovf = 1'b0;
    e.exc = 1'b0;
    e.res = '0;
    r     = 0;
    case (op)
      5'd1: begin r = sx(a) - sx(b); e.res = r[W-1:0]; e.ovf = (r != sx(r[W-1:0])); end
      5'd2: e.res = a & b;
      5'd3: e.res = a | b;
      5'd4: e.res = a << sh;
      5'd5: e.res = $signed(a) >>> sh;
      5'd6: begin r = sx(a) * sx(b); e.res = r[W-1:0]; e.ovf = (r != sx(r[W-1:0])); end
      5'd7: begin
        if (!DIV_EN || b == '0) e.exc = 1'b1;
        else begin r = sx(a) / sx(b); e.res = r[W-1:0]; e.ovf = (r != sx(r[W-1:0])); end
      end
      default: begin r = sx(a) + sx(b); e.res = r[W-1:0]; e.ovf = (r != sx(r[W-1:0])); end
    endcase
    return e;
  endfunction

  // Called at a negedge; drives start for one cycle and records the expected completion if accepted.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    exp_t e;
    ctrl_start     = 1'b1;
    ctrl_ALUopcode = op;
    data_operandA  = a;
    data_operandB  = b;
    ctrl_shiftamt  = sh;
    if (!(cyc >= busy_start && cyc < busy_end)) begin
      e = model(op, a, b, sh);
      e.due = cyc + 1 + (iterative(op, b) ? W : 0);
      if (iterative(op, b)) begin
        busy_start = cyc + 1;
        busy_end   = cyc + 1 + W;
      end
      q.push_back(e);
    end
    @(negedge clock);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_ready(input string name, input logic [W-1:0] res, input logic ovf,
                            input logic exc, input int lat, input int busy_cycles);
    int n;
    int bc;
    n  = 1;
    bc = busy ? 1 : 0;
    while (!data_ready && n < 40) begin
      @(negedge clock);
      n++;
      if (busy) bc++;
    end
    chk({name, "_ready_seen"}, data_ready, 1);
    if (data_ready) begin
      chk({name, "_result"}, data_result, res);
      chk({name, "_overflow"}, overflow, ovf);
      chk({name, "_exception"}, data_exception, exc);
    end
    if (lat > 0) chk({name, "_latency"}, n, lat);
    if (busy_cycles >= 0) chk({name, "_busy_cycles"}, bc, busy_cycles);
  endtask

  // Per-cycle compare against the model queue and busy window.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("cmp_ready", data_ready, 1);
        chk("cmp_result", data_result, q[0].res);
        chk("cmp_not_equal", isNotEqual, q[0].ne);
        chk("cmp_less_than", isLessThan, q[0].lt);
        chk("cmp_overflow", overflow, q[0].ovf);
        chk("cmp_exception", data_exception, q[0].exc);
        void'(q.pop_front());
      end else begin
        chk("cmp_no_ready", data_ready, 0);
      end
      chk("cmp_busy", busy, (cyc >= busy_start && cyc < busy_end));
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_result", data_result, 0);
    chk("rst_flags", {isNotEqual, isLessThan, overflow, data_exception}, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    // Reset aborting a multiply
    issue(5'd0, 32'd1, 32'd2, 5'd0);
    wait_ready("add_pre", 32'd3, 1'b0, 1'b0, 1, 0);
    issue(5'd6, 32'd3, 32'd5, 5'd0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    q.delete();
    busy_start = 0;
    busy_end   = 0;
    repeat (2) @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_result", data_result, 0);
    chk("abort_ne", isNotEqual, 0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    issue(5'd0, 32'd1, 32'd2, 5'd0);
    wait_ready("add_post", 32'd3, 1'b0, 1'b0, 1, 0);

    // Single-cycle ops
    issue(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
    wait_ready("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1, 0);
    issue(5'd5, 32'h8000_0000, 32'd0, 5'd4);
    wait_ready("sra", 32'hF800_0000, 1'b0, 1'b0, 1, 0);
    issue(5'd1, 32'd5, 32'd5, 5'd0);
    wait_ready("sub_eq", 32'd0, 1'b0, 1'b0, 1, 0);
    chk("sub_eq_ne", isNotEqual, 0);
    issue(5'd1, 32'h8000_0000, 32'd1, 5'd0);
    wait_ready("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1, 0);
    chk("sub_ovf_lt", isLessThan, 1);
    issue(5'd4, 32'd1, 32'd0, 5'd31);
    wait_ready("sll", 32'h8000_0000, 1'b0, 1'b0, 1, 0);
    issue(5'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    wait_ready("and", 32'h0000_F000, 1'b0, 1'b0, 1, 0);
    issue(5'd3, 32'h0000_F0F0, 32'h0000_0F00, 5'd0);
    wait_ready("or", 32'h0000_FFF0, 1'b0, 1'b0, 1, 0);
    issue(5'd9, 32'd2, 32'd3, 5'd0);
    wait_ready("unknown_as_add", 32'd5, 1'b0, 1'b0, 1, 0);
    // Back-to-back starts
    issue(5'd0, 32'd10, 32'd20, 5'd0);
    issue(5'd1, 32'd10, 32'd20, 5'd0);
    wait_ready("b2b_sub", 32'hFFFF_FFF6, 1'b0, 1'b0, 1, 0);

    // Signed multiply
    issue(5'd6, 32'hFFFF_FFF9, 32'd6, 5'd0);
    wait_ready("mul_neg", 32'hFFFF_FFD6, 1'b0, 1'b0, 33, 32);
    issue(5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0);
    wait_ready("mul_ovf", 32'd0, 1'b1, 1'b0, 33, 32);
    issue(5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    wait_ready("mul_min", 32'h8000_0000, 1'b1, 1'b0, 33, 32);

`ifdef ALU_DIV_EN
    issue(5'd7, 32'hFFFF_FFF9, 32'd2, 5'd0);
    wait_ready("div_neg", 32'hFFFF_FFFD, 1'b0, 1'b0, 33, 32);
    issue(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    wait_ready("div_min", 32'h8000_0000, 1'b1, 1'b0, 33, 32);
    issue(5'd7, 32'd9, 32'd0, 5'd0);
    wait_ready("div_zero", 32'd0, 1'b0, 1'b1, 1, 0);
    issue(5'd7, 32'd100, 32'hFFFF_FFF9, 5'd0);
    wait_ready("div_trunc", 32'hFFFF_FFF2, 1'b0, 1'b0, 33, 32);
`else
    issue(5'd7, 32'd10, 32'd2, 5'd0);
    wait_ready("div_disabled", 32'd0, 1'b0, 1'b1, 1, 0);
`endif

    // Start ignored while busy; start accepted in the ready cycle
    issue(5'd6, 32'd3, 32'd5, 5'd0);
    repeat (3) @(negedge clock);
    issue(5'd0, 32'd1, 32'd1, 5'd0);
    wait_ready("mul_ignore", 32'd15, 1'b0, 1'b0, -1, -1);
    issue(5'd0, 32'd1, 32'd1, 5'd0);
    wait_ready("add_in_ready", 32'd2, 1'b0, 1'b0, 1, 0);

    repeat (5) @(negedge clock);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the processor's single-cycle ALU.
- Adds signed multiply and divide as iterative multicycle operations behind a start/ready handshake.
- Sits in the execute stage; the pipeline stalls on busy and captures results on data_ready.
- All single-cycle ops keep the same opcode map, with results registered one cycle after start.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ctrl_start  input  1  request; sampled only when busy=0.
- data_operandA  input  WIDTH  operand A, signed.
- data_operandB  input  WIDTH  operand B, signed.
- ctrl_ALUopcode  input  5  operation select.
- ctrl_shiftamt  input  SHAMT_W  shift amount.
- data_result  output  WIDTH  registered result.
- isNotEqual  output  1  registered A!=B.
- isLessThan  output  1  registered signed A<B.
- overflow  output  1  registered signed overflow.
- data_exception  output  1  registered divide-by-zero / unsupported flag.
- data_ready  output  1  one-cycle pulse; result fields valid.
- busy  output  1  multicycle op in progress.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA (arithmetic), 6 MUL, 7 DIV.
  - Any other code executes as ADD.
- Reset (async): state IDLE; data_result=0; all flags, data_ready and busy = 0; iteration counter 0.
- States:
  - IDLE/DONE (busy=0): start accepted.
  - MUL, DIV (busy=1): iterating.
- Accept:
  - Start accepted only when busy=0.
  - On accept, operands, opcode and shamt are latched, and isNotEqual/isLessThan are computed from the latched operands.
  - Start while busy=1 is ignored, with no effect on the running op.
- Opcodes 0-5: result registered at the accepting edge; data_ready=1 for exactly the next cycle (latency 1).
  - Back-to-back starts every cycle are legal and give one ready pulse per start.
- MUL (6):
  - Shift-add over |A|,|B|; sign applied at the end.
  - busy=1 for WIDTH cycles after accept; data_ready pulses in cycle WIDTH+1; busy drops in the same cycle.
  - data_result = low WIDTH bits of the 2*WIDTH signed product.
  - overflow=1 if the high half is not the sign extension of the low half.
- DIV (7):
  - Restoring division on magnitudes; quotient truncated toward zero; remainder discarded.
  - Same latency as MUL.
  - B=0: no iteration; data_ready next cycle, data_result=0, data_exception=1.
  - A=MIN, B=-1: data_result=MIN, overflow=1.
- ADD/SUB overflow: operand signs equal (SUB: A vs ~B) and result sign differs.
- AND/OR/shift: overflow=0.
- data_exception=0 for all ops except those listed.
- Outputs hold their last completed values until the next completion; data_ready is 0 otherwise.
- A new start may be accepted in the same cycle data_ready is high, since busy=0 then.
- Reset asserted mid-MUL/DIV aborts the operation: no data_ready, outputs return to their reset values.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: DIV implemented as above.
- Undefined:
  - No divider datapath is synthesised.
  - Opcode 7 completes in 1 cycle with data_result=0, data_exception=1, overflow=0, busy never asserted.

Test Plan (WIDTH=32):
1. Reset mid-run: start MUL A=3 B=5, assert reset at cycle 10 -> busy=0, data_ready never pulses, data_result=0; next ADD 1+2 -> data_result=3, ready at cycle 1.
2. Single-cycle ops: ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1, ready 1 cycle later; SRA 0x80000000 by 4 -> 0xF8000000; SUB 5-5 -> 0, isNotEqual=0.
3. Signed multiply: MUL A=-7 B=6 -> data_result=0xFFFFFFD6 (-42), overflow=0, busy high 32 cycles, ready at cycle 33; MUL 0x10000*0x10000 -> 0, overflow=1.
4. Divide: DIV -7/2 -> 0xFFFFFFFD (-3); DIV 0x80000000/-1 -> 0x80000000, overflow=1; DIV 9/0 -> 0, data_exception=1, ready at cycle 1.
5. Handshake: during MUL, pulse start with ADD 1+1 at cycle 5 -> ignored, MUL result unchanged; start ADD in the ready cycle -> accepted, ready the following cycle with 2.
6. Build with ALU_DIV_EN undefined: DIV 10/2 -> data_result=0, data_exception=1, busy stays 0.
